tick_monitor: RTL

Receive-side companion to the board's tenth-second timer. It takes the timer's toggling tick output, a square wave that changes level once every 0.1 s, and synchronizes it. It converts each level change into a one-cycle pulse and keeps tenth/second/minute elapsed-time counters. It raises a sticky alarm when the tick stops toggling within a configured window, and sits between the timer and the status/LED and reporting logic.

---
 rtl/tick_monitor_if.sv | 22 ++
 rtl/tick_monitor.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tick_monitor_if.sv
// Bus between the tenth-second timer side and tick_monitor: tick input, clear,
// and the pulse/counter/alarm outputs consumed by status and reporting logic.
interface tick_monitor_if;
    logic       tick_in;
    logic       clr;
    logic       tick_pulse;
    logic       sec_tick;
    logic [3:0] tenth_cnt;
    logic [5:0] sec_cnt;
    logic [7:0] min_cnt;
    logic       tick_lost;

    modport master (
        output tick_in, clr,
        input  tick_pulse, sec_tick, tenth_cnt, sec_cnt, min_cnt, tick_lost
    );

    modport slave (
        input  tick_in, clr,
        output tick_pulse, sec_tick, tenth_cnt, sec_cnt, min_cnt, tick_lost
    );
endinterface

// File: rtl/tick_monitor.sv
// Synchronizes the timer's toggling tick, turns each level change into a pulse,
// keeps tenth/second/minute counters and raises a sticky alarm if ticks stop.
module tick_monitor #(
    parameter int          U_DLY          = 1,
    parameter logic [25:0] TIMEOUT_CYCLES = 26'd2999999
) (
    input  logic          clk,
    input  logic          rst,
    tick_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOST = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_s1, r_s2, r_s3;
    logic        w_edge;
    logic        w_count;
    logic        w_pulse;
    logic        w_timeout;
    logic        w_tenth_wrap;
    logic        w_sec_wrap;
    logic [25:0] r_gap_cnt;
    logic        r_tick_pulse;
    logic        r_sec_tick;
    logic [3:0]  r_tenth_cnt;
    logic [5:0]  r_sec_cnt;
    logic [7:0]  r_min_cnt;
    logic        r_tick_lost;

    // s1 may go metastable; only s2/s3 feed logic. clr leaves this chain running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.tick_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge       = r_s2 ^ r_s3;
    assign w_tenth_wrap = (r_tenth_cnt == 4'd9);
    assign w_sec_wrap   = (r_sec_cnt == 6'd59);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // The first edge after IDLE only arms; an edge beats a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_count     = 1'b0;
        w_pulse     = 1'b0;
        w_timeout   = 1'b0;
        if (bus.clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        w_state_nxt = S_RUN;
                        w_pulse     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_edge) begin
                        w_pulse = 1'b1;
                        w_count = 1'b1;
                    end else if (r_gap_cnt == TIMEOUT_CYCLES) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = S_LOST;
                    end
                end
                S_LOST: begin
                    if (w_edge) begin
                        w_state_nxt = S_RUN;
                        w_pulse     = 1'b1;
                        w_count     = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr)
            r_gap_cnt <= 26'd0;
        else if ((r_state == S_RUN) && !w_edge && !w_timeout)
            r_gap_cnt <= r_gap_cnt + 26'd1;
        else
            r_gap_cnt <= 26'd0;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_tick_pulse <= 1'b0;
            r_sec_tick   <= 1'b0;
            r_tenth_cnt  <= 4'd0;
            r_sec_cnt    <= 6'd0;
            r_min_cnt    <= 8'd0;
            r_tick_lost  <= 1'b0;
        end else begin
            r_tick_pulse <= w_pulse;
            r_sec_tick   <= w_count && w_tenth_wrap;
            if (w_timeout)
                r_tick_lost <= 1'b1;
            if (w_count) begin
                r_tenth_cnt <= w_tenth_wrap ? 4'd0 : r_tenth_cnt + 4'd1;
                if (w_tenth_wrap) begin
                    r_sec_cnt <= w_sec_wrap ? 6'd0 : r_sec_cnt + 6'd1;
                    if (w_sec_wrap)
                        r_min_cnt <= r_min_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.tick_pulse = r_tick_pulse;
    assign bus.sec_tick   = r_sec_tick;
    assign bus.tenth_cnt  = r_tenth_cnt;
    assign bus.sec_cnt    = r_sec_cnt;
    assign bus.min_cnt    = r_min_cnt;
    assign bus.tick_lost  = r_tick_lost;

endmodule
